// File: rtl/axi4_full_slave_mem.sv
// axi4_full_slave_mem: AXI4-Full slave backed by a word-addressed memory array.
// One write burst and one read burst can be in flight at once, on independent channels.
// Ports: S_AXI_ACLK / S_AXI_ARESET (async, active-high); AW, W and B write channels;
//        AR and R read channels. Lock/cache/prot/qos/user signals are not ported.
// Optional macro AXI_SLV_RANGE_CHECK_EN: a beat whose byte address lies beyond the memory
//   is an error beat. Its write is dropped and BRESP=SLVERR, or it reads back 0 with
//   RRESP=SLVERR. Without the macro, addresses wrap modulo the memory size.
module axi4_full_slave_mem #(
    parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_MEM_DEPTH_LOG2   = 10
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [7:0]                        S_AXI_AWLEN,
    input  logic [2:0]                        S_AXI_AWSIZE,
    input  logic [1:0]                        S_AXI_AWBURST,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WLAST,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [7:0]                        S_AXI_ARLEN,
    input  logic [2:0]                        S_AXI_ARSIZE,
    input  logic [1:0]                        S_AXI_ARBURST,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RLAST,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);

    localparam int ADDR_LSB  = $clog2(C_S_AXI_DATA_WIDTH / 8);
    localparam int STRB_W    = C_S_AXI_DATA_WIDTH / 8;
    localparam int MEM_WORDS = 1 << C_MEM_DEPTH_LOG2;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

    // FIXED bursts hold the address; WRAP is deliberately treated as INCR.
    function automatic logic [C_S_AXI_ADDR_WIDTH-1:0] next_addr(
        input logic [C_S_AXI_ADDR_WIDTH-1:0] a,
        input logic [2:0]                    size,
        input logic [1:0]                    burst
    );
        if (burst == 2'b00) return a;
        return a + (C_S_AXI_ADDR_WIDTH'(1) << size);
    endfunction

`ifdef AXI_SLV_RANGE_CHECK_EN
    function automatic logic out_of_range(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
        return (a >> (ADDR_LSB + C_MEM_DEPTH_LOG2)) != '0;
    endfunction
`endif

    // ---------------- write path ----------------
    typedef enum logic [1:0] {WIdle, WData, WResp} wstate_t;

    wstate_t                       w_state;
    logic [C_S_AXI_ID_WIDTH-1:0]   w_id;
    logic [C_S_AXI_ADDR_WIDTH-1:0] w_addr;
    logic [7:0]                    w_len, w_beat;
    logic [2:0]                    w_size;
    logic [1:0]                    w_burst;
    logic                          w_err;
    logic                          awready, wready, bvalid;
    logic [C_S_AXI_ID_WIDTH-1:0]   bid;
    logic [1:0]                    bresp;

    logic                          w_hs, w_beat_err, mem_we;
    logic [C_MEM_DEPTH_LOG2-1:0]   w_idx;

    always_comb begin
        w_hs       = wready && S_AXI_WVALID;
        w_idx      = w_addr[ADDR_LSB +: C_MEM_DEPTH_LOG2];
        // WLAST must be high on exactly the final beat.
        w_beat_err = S_AXI_WLAST != (w_beat == w_len);
        mem_we     = w_hs;
`ifdef AXI_SLV_RANGE_CHECK_EN
        if (out_of_range(w_addr)) begin
            w_beat_err = 1'b1;
            mem_we     = 1'b0;
        end
`endif
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            w_state <= WIdle;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_beat  <= '0;
            w_err   <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= 2'b00;
        end else begin
            unique case (w_state)
                WIdle: begin
                    if (awready && S_AXI_AWVALID) begin
                        w_id    <= S_AXI_AWID;
                        w_addr  <= S_AXI_AWADDR;
                        w_len   <= S_AXI_AWLEN;
                        w_size  <= S_AXI_AWSIZE;
                        w_burst <= S_AXI_AWBURST;
                        w_beat  <= '0;
                        w_err   <= 1'b0;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= WData;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                WData: begin
                    if (w_hs) begin
                        w_addr <= next_addr(w_addr, w_size, w_burst);
                        w_beat <= w_beat + 8'd1;
                        // Burst length is governed by AWLEN, never by WLAST.
                        if (w_beat == w_len) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bid     <= w_id;
                            bresp   <= (w_err || w_beat_err) ? 2'b10 : 2'b00;
                            w_state <= WResp;
                        end else begin
                            w_err <= w_err || w_beat_err;
                        end
                    end
                end
                WResp: begin
                    if (S_AXI_BREADY) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= WIdle;
                    end
                end
                default: w_state <= WIdle;
            endcase
        end
    end

    // Memory is intentionally not reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI_WSTRB[b]) mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    typedef enum logic {RIdle, RData} rstate_t;

    rstate_t                       r_state;
    logic [C_S_AXI_ADDR_WIDTH-1:0] r_addr, r_next;
    logic [7:0]                    r_len, r_beat, r_beat_nxt;
    logic [2:0]                    r_size;
    logic [1:0]                    r_burst;
    logic                          arready, rvalid, rlast;
    logic [C_S_AXI_ID_WIDTH-1:0]   rid;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata, ld_data;
    logic [1:0]                    rresp, ld_resp;
    logic [C_MEM_DEPTH_LOG2-1:0]   ld_idx;
    logic                          r_hs;

    // Data for the beat about to be presented: first beat from ARADDR, later beats from r_next.
    always_comb begin
        r_hs       = rvalid && S_AXI_RREADY;
        r_next     = next_addr(r_addr, r_size, r_burst);
        r_beat_nxt = r_beat + 8'd1;
        ld_idx     = (r_state == RIdle) ? S_AXI_ARADDR[ADDR_LSB +: C_MEM_DEPTH_LOG2]
                                        : r_next[ADDR_LSB +: C_MEM_DEPTH_LOG2];
        ld_data    = mem[ld_idx];
        ld_resp    = 2'b00;
`ifdef AXI_SLV_RANGE_CHECK_EN
        if ((r_state == RIdle) ? out_of_range(S_AXI_ARADDR) : out_of_range(r_next)) begin
            ld_data = '0;
            ld_resp = 2'b10;
        end
`endif
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_state <= RIdle;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_beat  <= '0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= 2'b00;
        end else begin
            unique case (r_state)
                RIdle: begin
                    if (arready && S_AXI_ARVALID) begin
                        r_addr  <= S_AXI_ARADDR;
                        r_len   <= S_AXI_ARLEN;
                        r_size  <= S_AXI_ARSIZE;
                        r_burst <= S_AXI_ARBURST;
                        r_beat  <= '0;
                        rid     <= S_AXI_ARID;
                        rdata   <= ld_data;
                        rresp   <= ld_resp;
                        rlast   <= (S_AXI_ARLEN == 8'd0);
                        rvalid  <= 1'b1;
                        arready <= 1'b0;
                        r_state <= RData;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                RData: begin
                    if (r_hs) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= RIdle;
                        end else begin
                            r_addr <= r_next;
                            r_beat <= r_beat_nxt;
                            rdata  <= ld_data;
                            rresp  <= ld_resp;
                            rlast  <= (r_beat_nxt == r_len);
                        end
                    end
                end
                default: r_state <= RIdle;
            endcase
        end
    end

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = wready;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BID     = bid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RID     = rid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = rresp;
    assign S_AXI_RLAST   = rlast;

endmodule
